// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and default sizes for the MEM stage SRAM path
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int unsigned DEF_BASE_ADDR = 1024;
  localparam int          SRAM_DW       = 16;
  localparam int          DEF_SRAM_AW   = 18;

endpackage

// File: rtl/mem_stage_sram_if.sv
// rtl/mem_stage_sram_if.sv - EXE/MEM request bus: load/store request in, load data and ready out
interface mem_stage_sram_if;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic [31:0] mem_result;
  logic        ready;

  modport master (
    output mem_read, mem_write, alu_res, st_val,
    input  mem_result, ready
  );

  modport slave (
    input  mem_read, mem_write, alu_res, st_val,
    output mem_result, ready
  );

endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - two-half-word SRAM access FSM with registered pin drivers and load capture
module sram_ctrl
  import mem_pkg::*;
#(
  parameter int HALF_CYCLES = 2,
  parameter int SRAM_AW     = DEF_SRAM_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   wr,
`ifdef MEM_ADDR_CHECK_EN
  input  logic                   skip,
  output logic                   addr_err,
`endif
  input  logic [SRAM_AW-2:0]     word,
  input  logic [31:0]            wdata,
  output mem_state_t             state,
  output logic [31:0]            rdata,
  output logic [SRAM_AW-1:0]     sram_addr,
  inout  wire  [SRAM_DW-1:0]     sram_dq,
  output logic                   sram_we_n
);

  localparam logic [2:0] LAST = 3'(HALF_CYCLES - 1);

  mem_state_t           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_q, oe_d;
  logic [SRAM_DW-1:0]   dout_q, dout_d;
  logic                 skip_now;

`ifdef MEM_ADDR_CHECK_EN
  logic err_q, err_d;
  assign skip_now = skip;
`else
  assign skip_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = 3'd0;
          state_d = skip_now ? DONE : LO;
        end
      end
      LO: begin
        if (cnt_q == LAST) begin
          cnt_d   = 3'd0;
          state_d = HI;
          if (!wr) rdata_d[15:0] = sram_dq;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HI: begin
        if (cnt_q == LAST) begin
          cnt_d   = 3'd0;
          state_d = DONE;
          if (!wr) rdata_d[31:16] = sram_dq;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered from the next state so we_n/oe come straight off flops.
  always_comb begin
    addr_d = '0;
    we_n_d = 1'b1;
    oe_d   = 1'b0;
    dout_d = '0;
    case (state_d)
      LO: begin
        addr_d = {word, 1'b0};
        we_n_d = !wr;
        oe_d   = wr;
        dout_d = wdata[15:0];
      end
      HI: begin
        addr_d = {word, 1'b1};
        we_n_d = !wr;
        oe_d   = wr;
        dout_d = wdata[31:16];
      end
      default: ;
    endcase
  end

`ifdef MEM_ADDR_CHECK_EN
  always_comb begin
    err_d = (state_q == IDLE) && req && skip;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
`ifdef MEM_ADDR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
`ifdef MEM_ADDR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign sram_dq   = oe_q ? dout_q : {SRAM_DW{1'bz}};
  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;
  assign state     = state_q;
  assign rdata     = rdata_q;
`ifdef MEM_ADDR_CHECK_EN
  assign addr_err  = err_q;
`endif

endmodule

// File: rtl/mem_stage_sram.sv
// rtl/mem_stage_sram.sv - MEM stage top: address map, request priority, ready; MEM_ADDR_CHECK_EN adds addr_err
module mem_stage_sram
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'(DEF_BASE_ADDR),
  parameter int          HALF_CYCLES = 2,
  parameter int          SRAM_AW     = DEF_SRAM_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_sram_if.slave      pipe,
  output logic [SRAM_AW-1:0]   sram_addr,
  inout  wire  [SRAM_DW-1:0]   sram_dq,
  output logic                 sram_we_n
`ifdef MEM_ADDR_CHECK_EN
  ,output logic                addr_err
`endif
);

  logic [31:0]        off;
  logic [SRAM_AW-2:0] word;
  logic               req;
  logic               wr;
  mem_state_t         state;
  logic [31:0]        rdata;
  logic               unused_off_bits;

  // Byte offset wraps modulo 2^32; the word index then wraps modulo the SRAM size.
  assign off             = pipe.alu_res - BASE_ADDR;
  assign word            = off[SRAM_AW:2];
  assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};

  assign req = pipe.mem_read | pipe.mem_write;
  assign wr  = pipe.mem_write;

  assign pipe.ready      = !(req && (state != DONE));
  assign pipe.mem_result = rdata;

`ifdef MEM_ADDR_CHECK_EN
  logic bad_addr;
  assign bad_addr = (pipe.alu_res < BASE_ADDR) || (pipe.alu_res[1:0] != 2'b00);
`endif

  sram_ctrl #(
    .HALF_CYCLES (HALF_CYCLES),
    .SRAM_AW     (SRAM_AW)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wr        (wr),
`ifdef MEM_ADDR_CHECK_EN
    .skip      (bad_addr),
    .addr_err  (addr_err),
`endif
    .word      (word),
    .wdata     (pipe.st_val),
    .state     (state),
    .rdata     (rdata),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_we_n (sram_we_n)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb/tb_mem_stage_sram.sv - directed bench for mem_stage_sram with a 16-bit async SRAM model
module tb_mem_stage_sram;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;

  logic [15:0] sram_mem [0:63];
  logic [17:0] addr_log [0:19];
  logic        we_log   [0:19];
  logic        err_log  [0:19];

  mem_stage_sram_if pif ();

`ifdef MEM_ADDR_CHECK_EN
  logic addr_err;
  mem_stage_sram dut (
    .clk(clk), .rst(rst), .pipe(pif), .sram_addr(sram_addr),
    .sram_dq(sram_dq), .sram_we_n(sram_we_n), .addr_err(addr_err)
  );
`else
  mem_stage_sram dut (
    .clk(clk), .rst(rst), .pipe(pif), .sram_addr(sram_addr),
    .sram_dq(sram_dq), .sram_we_n(sram_we_n)
  );
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq = sram_we_n ? sram_mem[sram_addr[5:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[5:0]] <= sram_dq;
  end

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int done);
    pif.mem_read  = rd;
    pif.mem_write = wr;
    pif.alu_res   = a;
    pif.st_val    = d;
    done = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      addr_log[c] = sram_addr;
      we_log[c]   = sram_we_n;
`ifdef MEM_ADDR_CHECK_EN
      err_log[c]  = addr_err;
`else
      err_log[c]  = 1'b0;
`endif
      if (pif.ready) begin
        done = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    pif.mem_read  = 1'b0;
    pif.mem_write = 1'b0;
  endtask

  task automatic test_reset();
    pif.mem_read = 1'b0; pif.mem_write = 1'b0; pif.alu_res = '0; pif.st_val = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (pif.mem_result !== 32'h0) $display("FAIL rst_result: got %h want 0", pif.mem_result); else passed++;
    total++; if (pif.ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", pif.ready); else passed++;
    total++; if (sram_we_n !== 1'b1) $display("FAIL rst_we_n: got %b want 1", sram_we_n); else passed++;
    total++; if (sram_addr !== 18'h0) $display("FAIL rst_addr: got %h want 0", sram_addr); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int done;
    do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, done);
    total++; if (done !== 5) $display("FAIL wr_latency: got %0d want 5", done); else passed++;
    total++; if (sram_mem[0] !== 16'hBEEF) $display("FAIL wr_lo: got %h want beef", sram_mem[0]); else passed++;
    total++; if (sram_mem[1] !== 16'hDEAD) $display("FAIL wr_hi: got %h want dead", sram_mem[1]); else passed++;
    total++; if (we_log[1] !== 1'b0 || we_log[3] !== 1'b0) $display("FAIL wr_we_n: got %b%b want 00", we_log[1], we_log[3]); else passed++;
    total++; if (addr_log[1] !== 18'd0 || addr_log[3] !== 18'd1) $display("FAIL wr_addr: got %0d/%0d want 0/1", addr_log[1], addr_log[3]); else passed++;
    total++; if (pif.mem_result !== 32'h0) $display("FAIL wr_keeps_result: got %h want 0", pif.mem_result); else passed++;
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, done);
    total++; if (done !== 5) $display("FAIL rd_latency: got %0d want 5", done); else passed++;
    total++; if (pif.mem_result !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", pif.mem_result); else passed++;
    total++; if (we_log[2] !== 1'b1 || we_log[4] !== 1'b1) $display("FAIL rd_we_n: got %b%b want 11", we_log[2], we_log[4]); else passed++;
  endtask

  task automatic test_addr_map();
    int done;
    do_access(1'b0, 1'b1, 32'd1032, 32'h22221111, done);
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, done);
    total++; if (addr_log[1] !== 18'd4 || addr_log[2] !== 18'd4) $display("FAIL map_lo: got %0d/%0d want 4/4", addr_log[1], addr_log[2]); else passed++;
    total++; if (addr_log[3] !== 18'd5 || addr_log[4] !== 18'd5) $display("FAIL map_hi: got %0d/%0d want 5/5", addr_log[3], addr_log[4]); else passed++;
    total++; if (pif.mem_result !== 32'h22221111) $display("FAIL map_data: got %h want 22221111", pif.mem_result); else passed++;
    for (int a = 1033; a <= 1035; a++) begin
      do_access(1'b1, 1'b0, 32'(a), 32'h0, done);
      total++;
      if (addr_log[1] !== 18'd4 || addr_log[3] !== 18'd5 || pif.mem_result !== 32'h22221111)
        $display("FAIL map_off%0d: got %0d/%0d %h want 4/5 22221111", a, addr_log[1], addr_log[3], pif.mem_result);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, d3, t0, t1;
    do_access(1'b0, 1'b1, 32'd1028, 32'hF00DCAFE, d1);
    t0 = cyc;
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, d1);
    total++; if (pif.mem_result !== 32'hDEADBEEF) $display("FAIL b2b_rd1: got %h want deadbeef", pif.mem_result); else passed++;
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, d2);
    total++; if (pif.mem_result !== 32'hF00DCAFE) $display("FAIL b2b_rd2: got %h want f00dcafe", pif.mem_result); else passed++;
    do_access(1'b0, 1'b1, 32'd1032, 32'hA5A55A5A, d3);
    t1 = cyc;
    total++; if (d1 !== 5 || d2 !== 5 || d3 !== 5) $display("FAIL b2b_done: got %0d/%0d/%0d want 5/5/5", d1, d2, d3); else passed++;
    total++; if (t1 - t0 !== 18) $display("FAIL b2b_cycles: got %0d want 18", t1 - t0); else passed++;
    total++; if (sram_mem[4] !== 16'h5A5A || sram_mem[5] !== 16'hA5A5) $display("FAIL b2b_wr: got %h%h want a5a55a5a", sram_mem[5], sram_mem[4]); else passed++;
    total++; if (pif.mem_result !== 32'hF00DCAFE) $display("FAIL b2b_wr_keeps: got %h want f00dcafe", pif.mem_result); else passed++;
    @(negedge clk);
    total++; if (sram_we_n !== 1'b1 || pif.ready !== 1'b1) $display("FAIL b2b_idle: got we_n=%b ready=%b want 1/1", sram_we_n, pif.ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_both();
    int done;
    do_access(1'b1, 1'b1, 32'd1040, 32'h12345678, done);
    total++; if (done !== 5) $display("FAIL both_latency: got %0d want 5", done); else passed++;
    total++; if (sram_mem[8] !== 16'h5678 || sram_mem[9] !== 16'h1234) $display("FAIL both_wr: got %h%h want 12345678", sram_mem[9], sram_mem[8]); else passed++;
    total++; if (pif.mem_result !== 32'hF00DCAFE) $display("FAIL both_result: got %h want f00dcafe", pif.mem_result); else passed++;
  endtask

  task automatic test_reset_mid();
    pif.mem_read = 1'b0; pif.mem_write = 1'b1; pif.alu_res = 32'd1044; pif.st_val = 32'h87654321;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (dut.u_ctrl.state_q !== IDLE) $display("FAIL rmid_state: got %0d want 0", dut.u_ctrl.state_q); else passed++;
    total++; if (sram_we_n !== 1'b1) $display("FAIL rmid_we_n: got %b want 1", sram_we_n); else passed++;
    total++; if (dut.u_ctrl.oe_q !== 1'b0) $display("FAIL rmid_dq_oe: got %b want 0", dut.u_ctrl.oe_q); else passed++;
    total++; if (pif.mem_result !== 32'h0) $display("FAIL rmid_result: got %h want 0", pif.mem_result); else passed++;
    total++; if (pif.ready !== 1'b0) $display("FAIL rmid_ready_req: got %b want 0", pif.ready); else passed++;
    #1 pif.mem_write = 1'b0;
    #1;
    total++; if (pif.ready !== 1'b1) $display("FAIL rmid_ready_noreq: got %b want 1", pif.ready); else passed++;
    @(posedge clk); #1;
  endtask

`ifdef MEM_ADDR_CHECK_EN
  task automatic test_addr_check();
    int done;
    logic [31:0] bad [0:1];
    bad[0] = 32'd1000;
    bad[1] = 32'd1026;
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, done);
    for (int i = 0; i < 2; i++) begin
      do_access(1'b1, 1'b0, bad[i], 32'h0, done);
      total++; if (done !== 1) $display("FAIL chk_latency%0d: got %0d want 1", i, done); else passed++;
      total++; if (err_log[1] !== 1'b1 || err_log[0] !== 1'b0) $display("FAIL chk_err%0d: got %b%b want 01", i, err_log[0], err_log[1]); else passed++;
      total++; if (we_log[0] !== 1'b1 || we_log[1] !== 1'b1) $display("FAIL chk_we_n%0d: got %b%b want 11", i, we_log[0], we_log[1]); else passed++;
      total++; if (pif.mem_result !== 32'hDEADBEEF) $display("FAIL chk_result%0d: got %h want deadbeef", i, pif.mem_result); else passed++;
      @(negedge clk);
      total++; if (addr_err !== 1'b0) $display("FAIL chk_err_clear%0d: got %b want 0", i, addr_err); else passed++;
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_addr_map();
    test_back_to_back();
    test_both();
    test_reset_mid();
`ifdef MEM_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
